// File: rtl/aww_types_pkg.sv
// Arbiter grant state encoding.
package aww_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath/RAM types: RAM status encoding and the machine word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the unified single-port RAM between instruction fetch and data access.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long a waiting fetch can be starved.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  arb_state_t state_q;
  logic       d_req;
  logic       ram_acc;
  logic       i_done;
  logic       d_done;
  logic       starve_go;

  assign d_req   = dREN | dWEN;
  assign ram_acc = (ramstate_t'(ramstate) == ACCESS);
  assign i_done  = (state_q == IGNT) & iREN & ram_acc;
  assign d_done  = (state_q == DGNT) & d_req & ram_acc;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // Counts data completions that overtook a pending fetch; saturates at STARVE_MAX.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!iREN) begin
      starve_cnt_d = '0;
    end else if (i_done) begin
      starve_cnt_d = '0;
    end else if (d_done && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_go = iREN & (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
  logic unused_starve;

  assign starve_go     = 1'b0;
  assign unused_starve = (STARVE_MAX != 0);
`endif

  // Grant FSM: one IDLE cycle between grants, no pre-emption, drop or completion releases.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (starve_go) begin
            state_q <= IGNT;
          end else if (d_req) begin
            state_q <= DGNT;
          end else if (iREN) begin
            state_q <= IGNT;
          end
        end
        IGNT: begin
          if (!iREN || ram_acc) begin
            state_q <= IDLE;
          end
        end
        DGNT: begin
          if (!d_req || ram_acc) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM and requester outputs follow the grant; a dropped request lowers enables at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~i_done;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~d_done;
      end
      default: ;
    endcase
  end

endmodule
